fetch_sequencer: RTL



---
 rtl/fetch_seq_pkg.sv | 24 ++
 rtl/seq_slot_counter.sv | 25 ++
 rtl/fetch_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared state encoding, default widths and slot-counter helpers for the fetch sequencer.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } seq_state_t;

    localparam int DEF_IMW = 4;
    localparam int DEF_DW  = 32;
    localparam int DEF_IW  = 32;
    localparam int DEF_RFW = 5;

    localparam int CNT_W = 4;

    // Terminal count for a slot counter that must span (depth - offset + 1) counts.
    function automatic logic [CNT_W-1:0] slot_last(input int depth, input int offset);
        return CNT_W'(depth - offset);
    endfunction

endpackage

// File: rtl/seq_slot_counter.sv
// 4-bit slot counter with clear, enable and terminal-count compare against a runtime value.
module seq_slot_counter
    import fetch_seq_pkg::*;
(
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_last,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tc = (r_count == i_last);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/writeback sequencer: PC generation, fill/drain tracking, branch redirect, halt and wrap.
// Optional wrong-path writeback squash after RUN branches is built when FETCH_SEQ_FLUSH_EN is defined.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int IMW        = DEF_IMW,
    parameter int PIPE_DEPTH = 4,
    parameter int RESET_VEC  = 0,
    parameter int PC_LAST    = (1 << IMW) - 1
) (
    input  logic           clk,
    input  logic           rf_reset,
    input  logic           start,
    input  logic           stall,
    input  logic           halt_req,
    input  logic           br_valid,
    input  logic [IMW-1:0] br_target,
    output logic [IMW-1:0] pc_in,
    output logic           im_cs,
    output logic           rf_we_e,
    output logic [2:0]     state,
    output logic           wrap
);

    localparam logic [IMW-1:0]   RV        = IMW'(RESET_VEC);
    localparam logic [IMW-1:0]   LAST      = IMW'(PC_LAST);
    localparam logic [CNT_W-1:0] SLOT_LAST = slot_last(PIPE_DEPTH, 1);

    seq_state_t     r_state;
    logic [IMW-1:0] r_pc;
    logic           r_im_cs;
    logic           r_rf_we;
    logic           r_wrap;

    logic [IMW-1:0] w_pc_nxt;
    logic           w_wrap_nxt;
    logic           w_fill_clr;
    logic           w_fill_en;
    logic           w_fill_tc;
    logic           w_drain_clr;
    logic           w_drain_en;
    logic           w_drain_tc;

    // Branch beats stall; otherwise a non-stalled cycle increments or wraps.
    always_comb begin
        w_pc_nxt   = r_pc;
        w_wrap_nxt = 1'b0;
        if (br_valid) begin
            w_pc_nxt = br_target;
        end else if (!stall) begin
            if (r_pc >= LAST) begin
                w_pc_nxt   = RV;
                w_wrap_nxt = 1'b1;
            end else begin
                w_pc_nxt = r_pc + IMW'(1);
            end
        end
    end

    assign w_fill_clr  = ((r_state == ST_IDLE) || (r_state == ST_HALTED)) && start;
    assign w_fill_en   = (r_state == ST_FILL) && !stall;
    assign w_drain_clr = (r_state == ST_RUN) && halt_req;
    assign w_drain_en  = (r_state == ST_DRAIN) && !stall;

    seq_slot_counter u_fill_cnt (
        .clk    (clk),
        .i_rst  (rf_reset),
        .i_clr  (w_fill_clr),
        .i_en   (w_fill_en),
        .i_last (SLOT_LAST),
        .o_tc   (w_fill_tc)
    );

    seq_slot_counter u_drain_cnt (
        .clk    (clk),
        .i_rst  (rf_reset),
        .i_clr  (w_drain_clr),
        .i_en   (w_drain_en),
        .i_last (SLOT_LAST),
        .o_tc   (w_drain_tc)
    );

`ifdef FETCH_SEQ_FLUSH_EN
    localparam logic [CNT_W-1:0] FLUSH_LAST = slot_last(PIPE_DEPTH, 2);

    logic r_flush;
    logic w_flush_set;
    logic w_flush_end;
    logic w_flush_tc;

    assign w_flush_set = (r_state == ST_RUN) && !halt_req && br_valid;
    assign w_flush_end = r_flush && !stall && w_flush_tc;

    // Restarts on every RUN branch, so a branch mid-flush extends the squash window.
    seq_slot_counter u_flush_cnt (
        .clk    (clk),
        .i_rst  (rf_reset),
        .i_clr  (w_flush_set),
        .i_en   (r_flush && !stall),
        .i_last (FLUSH_LAST),
        .o_tc   (w_flush_tc)
    );
`endif

    always_ff @(posedge clk) begin
        if (rf_reset) begin
            r_state <= ST_IDLE;
            r_pc    <= RV;
            r_im_cs <= 1'b0;
            r_rf_we <= 1'b0;
            r_wrap  <= 1'b0;
`ifdef FETCH_SEQ_FLUSH_EN
            r_flush <= 1'b0;
`endif
        end else begin
            r_wrap <= 1'b0;
`ifdef FETCH_SEQ_FLUSH_EN
            if (w_flush_end) begin
                r_flush <= 1'b0;
                r_rf_we <= 1'b1;
            end
            if (w_flush_set) begin
                r_flush <= 1'b1;
                r_rf_we <= 1'b0;
            end
`endif
            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        r_state <= ST_FILL;
                        r_im_cs <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (halt_req) begin
                        r_state <= ST_HALTED;
                        r_im_cs <= 1'b0;
                    end else begin
                        r_pc   <= w_pc_nxt;
                        r_wrap <= w_wrap_nxt;
                        if (!stall && w_fill_tc) begin
                            r_state <= ST_RUN;
                            r_rf_we <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (halt_req) begin
                        r_state <= ST_DRAIN;
                        r_im_cs <= 1'b0;
                    end else begin
                        r_pc   <= w_pc_nxt;
                        r_wrap <= w_wrap_nxt;
                    end
                end
                ST_DRAIN: begin
                    if (!stall && w_drain_tc) begin
                        r_state <= ST_HALTED;
                        r_rf_we <= 1'b0;
`ifdef FETCH_SEQ_FLUSH_EN
                        r_flush <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc_in   = r_pc;
    assign im_cs   = r_im_cs;
    assign rf_we_e = r_rf_we;
    assign state   = r_state;
    assign wrap    = r_wrap;

endmodule
